mem_port_arbiter: RTL and testbench

Shares a single Avalon-style memory port between the instruction-fetch and data-access sides of the Harvard MIPS core. It sequences each instruction as fetch, then an optional data access, then commit. It stalls the core through its `clk_enable` input until both transfers have completed. It sits between `mips_cpu_harvard` and a single-ported, wait-stated memory or bus.

---
 rtl/mips_bus_pkg.sv | 5 +
 rtl/mem_port_arbiter.sv | 67 ++++++
 tb/tb_mem_port_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and constants for the MIPS memory-port arbiter.
package mips_bus_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, FETCH = 2'b01, DATA = 2'b10, COMMIT = 2'b11} arb_state_t;
  localparam logic [127:0] BE_ALL = '1;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one wait-stated memory port between fetch and data, pulsing the core once per instruction.
module mem_port_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_active,
  input  logic [ADDR_W-1:0]   instr_address,
  output logic [DATA_W-1:0]   instr_readdata,
  input  logic [ADDR_W-1:0]   data_address,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [DATA_W-1:0]   data_writedata,
  input  logic [DATA_W/8-1:0] data_byteenable,
  output logic [DATA_W-1:0]   data_readdata,
  output logic                cpu_clk_enable,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                mem_waitrequest,
  output logic                bus_error
);
  localparam int BE_W = DATA_W / 8;
  arb_state_t state, next_state;
  logic fetch, xfer, rd_xfer;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = cpu_active ? FETCH : IDLE;
      FETCH:   next_state = mem_waitrequest ? FETCH : DATA;
      DATA:    next_state = (xfer && mem_waitrequest) ? DATA : COMMIT;
      COMMIT:  next_state = cpu_active ? FETCH : IDLE;
      default: next_state = IDLE;
    endcase
  end
  // A DATA cycle with no decoded request is a pass-through and drives nothing.
  always_comb begin
    fetch          = state == FETCH;
    xfer           = (state == DATA) && (data_read || data_write);
    rd_xfer        = xfer && data_read && !data_write;
    mem_read       = fetch || rd_xfer;
    mem_write      = xfer && data_write;
    mem_address    = fetch ? instr_address : xfer ? data_address : '0;
    mem_byteenable = fetch ? BE_ALL[BE_W-1:0] : xfer ? data_byteenable : '0;
    mem_writedata  = xfer ? data_writedata : '0;
    cpu_clk_enable = state == COMMIT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      instr_readdata <= '0;
      data_readdata  <= '0;
      bus_error      <= 1'b0;
    end else begin
      if (fetch && !mem_waitrequest) instr_readdata <= mem_readdata;
      if (rd_xfer && !mem_waitrequest) data_readdata <= mem_readdata;
      if (xfer && data_read && data_write) bus_error <= 1'b1;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cycle-by-cycle checks of the memory-port arbiter.
module tb_mem_port_arbiter;
  logic        clk = 0, reset = 1, cpu_active = 0;
  logic [31:0] instr_address = 0, instr_readdata, data_address = 0;
  logic        data_read = 0, data_write = 0;
  logic [31:0] data_writedata = 0, data_readdata, mem_address, mem_writedata, mem_readdata = 0;
  logic [3:0]  data_byteenable = 0, mem_byteenable;
  logic        cpu_clk_enable, mem_read, mem_write, mem_waitrequest = 0, bus_error;
  int total = 0, bad = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset), .cpu_active(cpu_active),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_readdata(data_readdata), .cpu_clk_enable(cpu_clk_enable),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #12;
    chk("rst_rd", mem_read, 0);
    chk("rst_wr", mem_write, 0);
    chk("rst_en", cpu_clk_enable, 0);
    chk("rst_err", bus_error, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_be", mem_byteenable, 0);
    chk("rst_ir", instr_readdata, 0);
    chk("rst_dr", data_readdata, 0);
    // plain instruction, zero waits
    instr_address = 32'h0BFC0000;
    mem_readdata = 32'h24020005;
    cpu_active = 1;
    reset = 0;
    cyc;
    chk("f1_rd", mem_read, 1);
    chk("f1_addr", mem_address, 32'h0BFC0000);
    chk("f1_be", mem_byteenable, 4'hF);
    chk("f1_en", cpu_clk_enable, 0);
    cyc;
    chk("f2_rd", mem_read, 0);
    chk("f2_ir", instr_readdata, 32'h24020005);
    chk("f2_en", cpu_clk_enable, 0);
    cyc;
    chk("f3_en", cpu_clk_enable, 1);
    // load with two wait states
    instr_address = 32'h4;
    mem_readdata = 32'h8C030000;
    data_read = 1;
    data_address = 32'h1000;
    data_byteenable = 4'hF;
    cyc;
    chk("l1_addr", mem_address, 32'h4);
    cyc;
    chk("l2_rd", mem_read, 1);
    chk("l2_addr", mem_address, 32'h1000);
    chk("l2_ir", instr_readdata, 32'h8C030000);
    mem_waitrequest = 1;
    mem_readdata = 32'h0;
    cyc;
    chk("l3_addr", mem_address, 32'h1000);
    chk("l3_en", cpu_clk_enable, 0);
    cyc;
    chk("l4_addr", mem_address, 32'h1000);
    chk("l4_rd", mem_read, 1);
    mem_waitrequest = 0;
    mem_readdata = 32'hDEADBEEF;
    cyc;
    chk("l5_en", cpu_clk_enable, 1);
    chk("l5_dr", data_readdata, 32'hDEADBEEF);
    chk("l5_rd", mem_read, 0);
    // store, halfword lanes
    instr_address = 32'h8;
    mem_readdata = 32'hAC040000;
    data_read = 0;
    data_write = 1;
    data_address = 32'h2000;
    data_writedata = 32'h12345678;
    data_byteenable = 4'b0011;
    cyc;
    chk("s1_wr", mem_write, 0);
    cyc;
    chk("s2_wr", mem_write, 1);
    chk("s2_rd", mem_read, 0);
    chk("s2_be", mem_byteenable, 4'b0011);
    chk("s2_wd", mem_writedata, 32'h12345678);
    chk("s2_addr", mem_address, 32'h2000);
    cyc;
    chk("s3_wr", mem_write, 0);
    chk("s3_rd", mem_read, 0);
    chk("s3_en", cpu_clk_enable, 1);
    chk("s3_err", bus_error, 0);
    // illegal simultaneous read and write
    data_read = 1;
    data_writedata = 32'hCAFEF00D;
    data_byteenable = 4'hF;
    cyc;
    cyc;
    chk("e2_wr", mem_write, 1);
    chk("e2_rd", mem_read, 0);
    chk("e2_wd", mem_writedata, 32'hCAFEF00D);
    cyc;
    chk("e3_err", bus_error, 1);
    chk("e3_en", cpu_clk_enable, 1);
    data_read = 0;
    data_write = 0;
    cyc;
    cyc;
    chk("e5_rd", mem_read, 0);
    chk("e5_wr", mem_write, 0);
    cyc;
    chk("e6_en", cpu_clk_enable, 1);
    chk("e6_err", bus_error, 1);
    // cpu_active drops while the data access is in progress
    data_read = 1;
    data_address = 32'h3000;
    mem_readdata = 32'h8C050000;
    cyc;
    mem_readdata = 32'h55AA55AA;
    cyc;
    chk("a2_rd", mem_read, 1);
    cpu_active = 0;
    cyc;
    chk("a3_en", cpu_clk_enable, 1);
    chk("a3_dr", data_readdata, 32'h55AA55AA);
    cyc;
    chk("a4_en", cpu_clk_enable, 0);
    chk("a4_rd", mem_read, 0);
    cyc;
    chk("a5_rd", mem_read, 0);
    chk("a5_err", bus_error, 1);
    // reset in the middle of a wait-stated fetch
    data_read = 0;
    instr_address = 32'h40;
    mem_waitrequest = 1;
    cpu_active = 1;
    cyc;
    chk("r1_rd", mem_read, 1);
    cyc;
    chk("r2_rd", mem_read, 1);
    chk("r2_addr", mem_address, 32'h40);
    reset = 1;
    #1;
    chk("r_rd", mem_read, 0);
    chk("r_addr", mem_address, 0);
    chk("r_err", bus_error, 0);
    chk("r_en", cpu_clk_enable, 0);
    cyc;
    chk("r3_en", cpu_clk_enable, 0);
    chk("r3_rd", mem_read, 0);
    cpu_active = 0;
    reset = 0;
    cyc;
    chk("r4_rd", mem_read, 0);
    chk("r4_en", cpu_clk_enable, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
